// File: rtl/approx_arith_pkg.sv
// rtl/approx_arith_pkg.sv - shared types and sizing helpers for the approximate arithmetic family
package approx_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N = 8;
  localparam int DEF_K = 4;

  // Counter must hold 0..K; guard K<1 so a bad parameter still elaborates.
  function automatic int step_cnt_w(input int k);
    return (k < 1) ? 1 : $clog2(k + 1);
  endfunction

  // Quotient bit just below the exact MSBs; 0 when K==N (then unused).
  function automatic int comp_bit_idx(input int n, input int k);
    return (k < n) ? (n - k - 1) : 0;
  endfunction

  localparam int DEF_COMP_IDX = comp_bit_idx(DEF_N, DEF_K);

endpackage

// File: rtl/approx_div_step.sv
// rtl/approx_div_step.sv - one restoring-division iteration: shift in a bit, compare, subtract
module approx_div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_rem,
  output logic         o_qbit
);

  logic [N:0] w_shifted;
  logic [N:0] w_diff;

  // Incoming rem is always < divisor, so the N+1-bit shifted value never wraps
  // and the restored/subtracted result always fits back into N bits.
  assign w_shifted = {i_rem, i_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
  assign o_rem     = o_qbit ? w_diff[N-1:0] : w_shifted[N-1:0];

endmodule

// File: rtl/approx_divider_seq.sv
// rtl/approx_divider_seq.sv - iterative approximate divider, top K quotient bits exact (DIV_ERR_COMP_EN adds midpoint bit)
module approx_divider_seq
  import approx_arith_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = step_cnt_w(K);
  localparam int SH = N - K;
  localparam int CI = comp_bit_idx(N, K);
`ifdef DIV_ERR_COMP_EN
  localparam logic [N-1:0] COMP_MASK = (K < N) ? (N'(1) << CI) : '0;
`else
  localparam logic [N-1:0] COMP_MASK = '0;
`endif

  state_e         r_state;
  state_e         w_state_next;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_shift;
  logic [N-1:0]   r_div;
  logic [N-1:0]   r_qacc;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_remout;
  logic           r_dbz;
  logic           r_ovf;

  logic           w_accept;
  logic           w_zero;
  logic           w_ovf;
  logic           w_last;
  logic [N-1:0]   w_step_rem;
  logic           w_qbit;
  logic [N-1:0]   w_qacc_next;
  logic [N-1:0]   w_quot_final;

  approx_div_step #(.N(N)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_shift[N-1]),
    .i_divisor (r_div),
    .o_rem     (w_step_rem),
    .o_qbit    (w_qbit)
  );

  assign w_accept     = (r_state == ST_IDLE) && in_valid;
  assign w_zero       = (divisor == '0);
  assign w_ovf        = (dividend[2*N-1:N] >= divisor);
  assign w_last       = (r_cnt == CW'(K - 1));
  assign w_qacc_next  = (r_qacc << 1) | N'(w_qbit);
  assign w_quot_final = (w_qacc_next << SH) | COMP_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (w_zero || w_ovf) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_shift  <= '0;
      r_div    <= '0;
      r_qacc   <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_rem    <= dividend[2*N-1:N];
      r_shift  <= dividend[N-1:0];
      r_div    <= divisor;
      r_qacc   <= '0;
      r_cnt    <= '0;
      r_remout <= '0;
      r_dbz    <= w_zero;
      r_ovf    <= !w_zero && w_ovf;
      r_quot   <= (w_zero || w_ovf) ? '1 : '0;
    end else if (r_state == ST_CALC) begin
      r_rem   <= w_step_rem;
      r_shift <= r_shift << 1;
      r_qacc  <= w_qacc_next;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_quot   <= w_quot_final;
        r_remout <= w_step_rem;
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remout;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_approx_divider_seq.sv
// tb/tb_approx_divider_seq.sv - self-checking bench for approx_divider_seq (N=8, K=4)
module tb_approx_divider_seq;

  localparam int N = 8;
  localparam int K = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int total;
  int bad;

  typedef struct {
    logic [2*N-1:0] p;
    logic [N-1:0]   b;
  } op_t;

  op_t pending[$];

  approx_divider_seq #(.N(N), .K(K)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: divide the dividend with its low N-K bits discarded.
  function automatic logic [2*N+1:0] ref_div(input logic [2*N-1:0] p, input logic [N-1:0] b);
    int unsigned pt;
    int unsigned q;
    int unsigned r;
    logic [N-1:0] qv;
    logic [N-1:0] rv;
    if (b == 0) return {{N{1'b1}}, {N{1'b0}}, 1'b1, 1'b0};
    if ((p / (2 ** N)) >= b) return {{N{1'b1}}, {N{1'b0}}, 1'b0, 1'b1};
    pt = p / (2 ** (N - K));
    q  = (pt / b) * (2 ** (N - K));
    r  = pt % b;
`ifdef DIV_ERR_COMP_EN
    if (K < N) q = q + (2 ** (N - K - 1));
`endif
    qv = q[N-1:0];
    rv = r[N-1:0];
    return {qv, rv, 1'b0, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [2*N-1:0] p, input logic [N-1:0] b,
                          output int lat, output bit timed_out);
    int n;
    dividend  = p;
    divisor   = b;
    in_valid  = 1'b1;
    timed_out = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) timed_out = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b want rdy=1 vld=0 q=00 r=00 dbz=0 ovf=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [2*N-1:0] tp [4];
    logic [N-1:0]   tb_ [4];
    logic [N-1:0]   tq [4];
    logic [N-1:0]   tr [4];
    logic           tz [4];
    logic           to [4];
    int             tl [4];
    int  lat;
    bit  tmo;
    tp[0] = 16'h1234; tb_[0] = 8'h56; tr[0] = 8'h21; tz[0] = 0; to[0] = 0; tl[0] = K;
    tp[1] = 16'h00FF; tb_[1] = 8'h01; tr[1] = 8'h00; tz[1] = 0; to[1] = 0; tl[1] = K;
    tp[2] = 16'h5000; tb_[2] = 8'h50; tr[2] = 8'h00; tz[2] = 0; to[2] = 1; tl[2] = 0;
    tp[3] = 16'h1234; tb_[3] = 8'h00; tr[3] = 8'h00; tz[3] = 1; to[3] = 0; tl[3] = 0;
`ifdef DIV_ERR_COMP_EN
    tq[0] = 8'h38; tq[1] = 8'hF8;
`else
    tq[0] = 8'h30; tq[1] = 8'hF0;
`endif
    tq[2] = 8'hFF; tq[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      issue_op(tp[i], tb_[i], lat, tmo);
      total++;
      if (tmo) begin
        bad++;
        $display("FAIL directed_%0d_timeout: got no result want result", i);
      end
      total++;
      if (lat !== tl[i]) begin
        bad++;
        $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, tl[i]);
      end
      total++;
      if ({quotient, remainder, div_by_zero, overflow} !== {tq[i], tr[i], tz[i], to[i]}) begin
        bad++;
        $display("FAIL directed_%0d_result: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                 i, quotient, remainder, div_by_zero, overflow, tq[i], tr[i], tz[i], to[i]);
      end
      release_result();
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
        bad++;
        $display("FAIL directed_%0d_handoff: got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit tmo;
    logic [2*N+1:0] exp;
    logic [2*N-1:0] p;
    logic [N-1:0]   b;
    b = 8'($urandom_range(1, 255));
    p = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
    exp = ref_div(p, b);
    issue_op(p, b, lat, tmo);
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL backpressure_timeout: got no result want result");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, exp}) begin
        bad++;
        $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b q=%h r=%h dbz=%b ovf=%b want vld=1 rdy=0 q=%h r=%h dbz=%b ovf=%b",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero, overflow,
                 exp[2*N+1:N+2], exp[N+1:2], exp[1], exp[0]);
      end
    end
    release_result();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midcalc();
    int lat;
    bit tmo;
    dividend = 16'h1234;
    divisor  = 8'h56;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_midcalc: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b want rdy=1 vld=0 q=00 r=00 dbz=0 ovf=0",
               in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
    end
    #10;
    rst_n = 1'b1;
    tick();
    issue_op(16'h1234, 8'h56, lat, tmo);
    total++;
    if (tmo || lat !== K || {quotient, remainder, div_by_zero, overflow} !== ref_div(16'h1234, 8'h56)) begin
      bad++;
      $display("FAIL reset_recover: got tmo=%b lat=%0d q=%h r=%h want lat=%0d q/r=%h", tmo, lat,
               quotient, remainder, K, ref_div(16'h1234, 8'h56));
    end
    release_result();
  endtask

  function automatic op_t rand_op();
    op_t o;
    int sel;
    sel = $urandom_range(0, 15);
    o.b = 8'($urandom);
    o.p = 16'($urandom);
    if (sel == 0) o.b = 8'h00;
    else if (sel < 12 && o.b != 0) o.p[15:8] = 8'($urandom_range(0, int'(o.b) - 1));
    return o;
  endfunction

  task automatic test_back_to_back();
    op_t cur;
    op_t front;
    logic [2*N+1:0] exp;
    bit acc;
    bit hs;
    int done;
    int cycles;
    pending.delete();
    cur = rand_op();
    dividend = cur.p;
    divisor  = cur.b;
    in_valid = 1'b1;
    out_ready = 1'($urandom);
    done = 0;
    cycles = 0;
    while (done < 1000 && cycles < 30000) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        total++;
        if (pending.size() == 0) begin
          bad++;
          $display("FAIL b2b_spurious: got result q=%h with nothing outstanding want none", quotient);
        end else begin
          front = pending[0];
          exp = ref_div(front.p, front.b);
          if ({quotient, remainder, div_by_zero, overflow} !== exp) begin
            bad++;
            $display("FAIL b2b_result_%0d: P=%h B=%h got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                     done, front.p, front.b, quotient, remainder, div_by_zero, overflow,
                     exp[2*N+1:N+2], exp[N+1:2], exp[1], exp[0]);
          end
        end
        done++;
      end
      tick();
      if (acc) begin
        pending.push_back(cur);
        cur = rand_op();
        dividend = cur.p;
        divisor  = cur.b;
      end
      if (hs && pending.size() != 0) void'(pending.pop_front());
      out_ready = 1'($urandom);
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (done !== 1000) begin
      bad++;
      $display("FAIL b2b_count: got %0d results want 1000", done);
    end
    total++;
    if (pending.size() !== 0) begin
      bad++;
      $display("FAIL b2b_leftover: got %0d outstanding want 0", pending.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midcalc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
